joy_db9md_multi: RTL and testbench

// - Scans 1..2**SEL_W Megadrive/SMS pads on DB9 splitter hardware. Pads share one 6-bit input bus,

---
 rtl/joy_db9md_multi_if.sv | 21 ++
 rtl/joy_db9md_multi.sv | 96 +++++++++
 tb/tb_joy_db9md_multi.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/joy_db9md_multi_if.sv
// joy_db9md_multi_if: pad-side and host-side signals of the DB9 splitter scanner
interface joy_db9md_multi_if #(
  parameter int SEL_W = 1
);
  localparam int N = 2 ** SEL_W;
  localparam int SW = (SEL_W > 0) ? SEL_W : 1;
  logic [5:0] joy_in;
  logic joy_mdsel;
  logic [SW-1:0] joy_split;
  logic [12*N-1:0] joystick;
  logic [2*N-1:0] pad_type;
  logic frame_strobe;
  modport master (
    input joy_in,
    output joy_mdsel, joy_split, joystick, pad_type, frame_strobe
  );
  modport slave (
    output joy_in,
    input joy_mdsel, joy_split, joystick, pad_type, frame_strobe
  );
endinterface

// File: rtl/joy_db9md_multi.sv
// joy_db9md_multi: clk-domain Megadrive/SMS pad scanner for DB9 splitters with per-port type detection
module joy_db9md_multi #(
  parameter int SEL_W = 1,
  parameter int SLOT_CYC = 16,
  parameter int IDLE_PHASES = 248
) (
  input logic clk,
  input logic reset,
  joy_db9md_multi_if.master bus
);
  localparam int N = 2 ** SEL_W;
  localparam int SW = (SEL_W > 0) ? SEL_W : 1;
  localparam int NPH = 8 + IDLE_PHASES;
  localparam int CW = $clog2(SLOT_CYC);
  localparam int PW = $clog2(NPH);
  logic [5:0] sync1_q, sync2_q;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [SW-1:0] port_q, port_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [5:0] hi_q [N], hi_d [N];
  logic [1:0] st_a_q [N], st_a_d [N];
  logic [3:0] ext_q [N], ext_d [N];
  logic [N-1:0] md_q, md_d, six_q, six_d;
  logic [12*N-1:0] joystick_q, joystick_d;
  logic [2*N-1:0] pad_type_q, pad_type_d;
  logic strobe_q, strobe_d;
  logic last_cyc, last_port, slot_end, end_p7;
  always_comb begin
    last_cyc = cyc_q == CW'(SLOT_CYC - 1);
    last_port = port_q == SW'(N - 1);
    slot_end = last_cyc & last_port;
    end_p7 = slot_end & (phase_q == PW'(7));
    cyc_d = last_cyc ? '0 : cyc_q + 1'b1;
    port_d = last_cyc ? (last_port ? '0 : port_q + 1'b1) : port_q;
    phase_d = slot_end ? ((phase_q == PW'(NPH - 1)) ? '0 : phase_q + 1'b1) : phase_q;
    hi_d = hi_q;
    st_a_d = st_a_q;
    ext_d = ext_q;
    md_d = md_q;
    six_d = six_q;
    if (last_cyc) begin
      if (phase_q == PW'(0)) hi_d[port_q] = sync2_q;
      if (phase_q == PW'(1)) begin
        md_d[port_q] = sync2_q[1:0] == 2'b00;
        st_a_d[port_q] = sync2_q[5:4];
      end
      if (phase_q == PW'(5)) six_d[port_q] = md_q[port_q] & (sync2_q[3:0] == 4'b0000);
      if (phase_q == PW'(6)) ext_d[port_q] = sync2_q[3:0];
    end
    joystick_d = joystick_q;
    pad_type_d = pad_type_q;
    strobe_d = end_p7;
    // {Mode, Start, Z, Y, X, A, C, B, U, D, L, R}; pins are active-low
    if (end_p7)
      for (int k = 0; k < N; k++) begin
        joystick_d[12*k +: 12] = {six_q[k] & ~ext_q[k][0], md_q[k] & ~st_a_q[k][1],
                                  {3{six_q[k]}} & ~ext_q[k][3:1], md_q[k] & ~st_a_q[k][0], ~hi_q[k]};
        pad_type_d[2*k +: 2] = six_q[k] ? 2'd2 : {1'b0, md_q[k]};
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      cyc_q <= '0;
      port_q <= '0;
      phase_q <= '0;
      hi_q <= '{default: '0};
      st_a_q <= '{default: '0};
      ext_q <= '{default: '0};
      md_q <= '0;
      six_q <= '0;
      joystick_q <= '0;
      pad_type_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      sync1_q <= bus.joy_in;
      sync2_q <= sync1_q;
      cyc_q <= cyc_d;
      port_q <= port_d;
      phase_q <= phase_d;
      hi_q <= hi_d;
      st_a_q <= st_a_d;
      ext_q <= ext_d;
      md_q <= md_d;
      six_q <= six_d;
      joystick_q <= joystick_d;
      pad_type_q <= pad_type_d;
      strobe_q <= strobe_d;
    end
  assign bus.joy_mdsel = (phase_q <= PW'(7)) ? ~phase_q[0] : 1'b1;
  assign bus.joy_split = port_q;
  assign bus.joystick = joystick_q;
  assign bus.pad_type = pad_type_q;
  assign bus.frame_strobe = strobe_q;
endmodule

// File: tb/tb_joy_db9md_multi.sv
// tb_joy_db9md_multi: behavioural pad models on a 2-port splitter versus button-level expectations
module tb_joy_db9md_multi;
  localparam int N = 2;
  localparam int SMS = 0, MD3 = 1, MD6 = 2, NONE = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int ptype [N];
  logic [11:0] btn [N];
  int th_cnt = 0, hi_run = 0;
  logic th_prev = 1'b1;
  int vectors = 0, errors = 0;
  joy_db9md_multi_if #(.SEL_W(1)) bus ();
  joy_db9md_multi #(.SEL_W(1), .SLOT_CYC(16), .IDLE_PHASES(248)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // 6-button pads count TH transitions and forget them after a long TH-high stretch
  always @(negedge clk)
    if (reset) begin
      th_cnt <= 0;
      hi_run <= 0;
      th_prev <= 1'b1;
    end else begin
      th_prev <= bus.joy_mdsel;
      hi_run <= bus.joy_mdsel ? hi_run + 1 : 0;
      if (bus.joy_mdsel && hi_run > 100) th_cnt <= 0;
      else if (bus.joy_mdsel != th_prev) th_cnt <= th_cnt + 1;
    end
  function automatic logic [5:0] pad_pins(int t, logic [11:0] b, logic th, int c);
    if (t == NONE) return 6'h3F;
    if (t == SMS || (th && !(t == MD6 && c == 6))) return ~b[5:0];
    if (th) return ~{b[5:4], b[9:7], b[11]};
    if (t == MD6 && c == 5) return {~b[10], ~b[6], 4'b0000};
    return {~b[10], ~b[6], ~b[2], ~b[3], 2'b00};
  endfunction
  assign bus.joy_in = pad_pins(ptype[bus.joy_split], btn[bus.joy_split], bus.joy_mdsel, th_cnt);
  function automatic logic [11:0] exp_joy(int t, logic [11:0] b);
    return (t == SMS) ? (b & 12'h03F) : (t == MD3) ? (b & 12'h47F) : (t == MD6) ? b : 12'h000;
  endfunction
  function automatic logic [1:0] exp_type(int t);
    return (t == MD3) ? 2'd1 : (t == MD6) ? 2'd2 : 2'd0;
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check_ports();
    for (int k = 0; k < N; k++) begin
      check($sformatf("joy%0d", k), 32'(bus.joystick[12*k +: 12]), 32'(exp_joy(ptype[k], btn[k])));
      check($sformatf("type%0d", k), 32'(bus.pad_type[2*k +: 2]), 32'(exp_type(ptype[k])));
    end
  endtask
  task automatic wait_strobe();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 9000 && !ok; i++) begin
      tick(1);
      ok = bus.frame_strobe;
    end
    check("strobe_seen", 32'(ok), 32'd1);
  endtask
  task automatic timing_run(int c, logic [11:0] exp);
    reset = 1'b1;
    ptype = '{SMS, NONE};
    btn = '{12'h000, 12'h000};
    tick(2);
    reset = 1'b0;
    tick(c);
    btn[0] = 12'h008;
    tick(256 - c);
    check($sformatf("tstrobe_c%0d", c), 32'(bus.frame_strobe), 32'd1);
    check($sformatf("tjoy_c%0d", c), 32'(bus.joystick[11:0]), 32'(exp));
  endtask
  task automatic rand_pad(int k);
    ptype[k] = int'($urandom_range(0, 3));
    btn[k] = 12'($urandom);
    if (ptype[k] == SMS && btn[k][0]) btn[k][1] = 1'b0;
    if (ptype[k] == MD3 && btn[k][2]) btn[k][3] = 1'b0;
  endtask
  initial begin
    ptype = '{MD3, NONE};
    btn = '{12'h410, 12'h000};
    tick(3);
    check("rst_mdsel", 32'(bus.joy_mdsel), 32'd1);
    check("rst_split", 32'(bus.joy_split), 32'd0);
    check("rst_joy", 32'(bus.joystick), 32'd0);
    check("rst_type", 32'(bus.pad_type), 32'd0);
    check("rst_strobe", 32'(bus.frame_strobe), 32'd0);
    reset = 1'b0;
    tick(15);
    check("split_c15", 32'(bus.joy_split), 32'd0);
    tick(1);
    check("split_c16", 32'(bus.joy_split), 32'd1);
    tick(15);
    check("mdsel_c31", 32'(bus.joy_mdsel), 32'd1);
    tick(1);
    check("mdsel_c32", 32'(bus.joy_mdsel), 32'd0);
    check("split_c32", 32'(bus.joy_split), 32'd0);
    tick(223);
    check("strobe_c255", 32'(bus.frame_strobe), 32'd0);
    tick(1);
    check("strobe_c256", 32'(bus.frame_strobe), 32'd1);
    check_ports();
    tick(1);
    check("strobe_c257", 32'(bus.frame_strobe), 32'd0);
    check("hold_joy", 32'(bus.joystick[11:0]), 32'h410);
    tick(8192 + 100 - 257);
    check("mdsel_p3", 32'(bus.joy_mdsel), 32'd0);
    reset = 1'b1;
    tick(1);
    check("midrst_mdsel", 32'(bus.joy_mdsel), 32'd1);
    check("midrst_joy", 32'(bus.joystick), 32'd0);
    check("midrst_strobe", 32'(bus.frame_strobe), 32'd0);
    reset = 1'b0;
    tick(31);
    check("re_mdsel_c31", 32'(bus.joy_mdsel), 32'd1);
    tick(1);
    check("re_mdsel_c32", 32'(bus.joy_mdsel), 32'd0);
    tick(224);
    check("re_strobe_c256", 32'(bus.frame_strobe), 32'd1);
    check_ports();
    timing_run(12, 12'h008);
    timing_run(15, 12'h000);
    ptype = '{MD3, MD6};
    btn = '{12'h410, 12'h880};
    wait_strobe();
    check_ports();
    ptype[1] = MD3;
    btn[1] = 12'hBB0;
    wait_strobe();
    check_ports();
    ptype = '{SMS, NONE};
    btn = '{12'h458, 12'h000};
    wait_strobe();
    check_ports();
    for (int f = 0; f < 3; f++) begin
      rand_pad(0);
      rand_pad(1);
      wait_strobe();
      check_ports();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
